// File: rtl/cntr_seq_pkg.sv
// Shared definitions for the counter sequencer: FSM state type and
// default widths for the counter and the repeat field.
package cntr_seq_pkg;

  localparam int unsigned CNT_W_DEF  = 4;
  localparam int unsigned REPS_W_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_HOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cntr_seq_core.sv
// CNT_W-bit up/down counter with synchronous load and count enable.
// Load has priority over enable; stepping wraps modulo 2^CNT_W.
module cntr_seq_core
  import cntr_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic             up_dnb,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counter register: load, else step in the selected direction, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= up_dnb ? (cnt + ONE) : (cnt - ONE);
    end
  end

endmodule

// File: rtl/cntr_seq_ctrl.sv
// Counter sequencer: accepts a command (start, end, direction, repeat
// count), then runs reps+1 passes of the counter from start to end.
// Supports pause (freeze via HOLD) and abort (drop back to IDLE).
module cntr_seq_ctrl
  import cntr_seq_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned REPS_W = REPS_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_start,
  input  logic [CNT_W-1:0]  cmd_end,
  input  logic              cmd_up_dnb,
  input  logic [REPS_W-1:0] cmd_reps,
  input  logic              pause,
  input  logic              abort,
  output logic [CNT_W-1:0]  cnt,
  output logic              busy,
  output logic              tc,
  output logic              done
);

  localparam logic [REPS_W-1:0] REPS_ONE = {{(REPS_W-1){1'b0}}, 1'b1};

  state_t              state, state_nx;
  logic [CNT_W-1:0]    start_q, end_q;
  logic                up_q;
  logic [REPS_W-1:0]   reps_q;
  logic [REPS_W-1:0]   pass_cnt;

  logic                capture;
  logic                pass_inc;
  logic                core_load;
  logic                core_en;

  cntr_seq_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (core_load),
    .en       (core_en),
    .up_dnb   (up_q),
    .load_val (start_q),
    .cnt      (cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Command capture; values stay frozen until the next accepted command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= '0;
      end_q   <= '0;
      up_q    <= 1'b0;
      reps_q  <= '0;
    end else if (capture) begin
      start_q <= cmd_start;
      end_q   <= cmd_end;
      up_q    <= cmd_up_dnb;
      reps_q  <= cmd_reps;
    end
  end

  // Completed-pass counter, cleared when a command is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_cnt <= '0;
    end else if (capture) begin
      pass_cnt <= '0;
    end else if (pass_inc) begin
      pass_cnt <= pass_cnt + REPS_ONE;
    end
  end

  // Next-state and control decode; priority abort > pause > compare > step.
  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    pass_inc  = 1'b0;
    core_load = 1'b0;
    core_en   = 1'b0;
    tc        = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          capture  = 1'b1;
          state_nx = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else begin
          core_load = 1'b1;
          state_nx  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (pause) begin
          state_nx = ST_HOLD;
        end else if (cnt == end_q) begin
          tc = 1'b1;
          if (pass_cnt == reps_q) begin
            state_nx = ST_DONE;
          end else begin
            core_load = 1'b1;
            pass_inc  = 1'b1;
          end
        end else begin
          core_en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (!pause) begin
          state_nx = ST_RUN;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_cntr_seq_ctrl.sv
// Scoreboard bench for cntr_seq_ctrl: the stimulus pushes one expected
// {cnt, tc, done} record per busy cycle; the monitor pops and compares on
// every falling edge where busy is high.
module tb_cntr_seq_ctrl;

  typedef struct packed {
    logic [3:0] cnt;
    logic       tc;
    logic       done;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_start;
  logic [3:0] cmd_end;
  logic       cmd_up_dnb;
  logic [1:0] cmd_reps;
  logic       pause;
  logic       abort;
  logic [3:0] cnt;
  logic       busy;
  logic       tc;
  logic       done;

  int   n_vec = 0;
  int   n_err = 0;
  rec_t exp_q[$];

  cntr_seq_ctrl #(
    .CNT_W  (4),
    .REPS_W (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_end    (cmd_end),
    .cmd_up_dnb (cmd_up_dnb),
    .cmd_reps   (cmd_reps),
    .pause      (pause),
    .abort      (abort),
    .cnt        (cnt),
    .busy       (busy),
    .tc         (tc),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Monitor: one record per busy cycle; anything extra is a miscompare.
  always @(negedge clk) begin
    if (busy) begin
      rec_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_busy_cycle: got cnt=%0d tc=%0b done=%0b, expected idle",
                 cnt, tc, done);
      end else begin
        e = exp_q.pop_front();
        if ({cnt, tc, done, cmd_ready} !== {e.cnt, e.tc, e.done, 1'b0}) begin
          n_err++;
          $display("FAIL seq_record: got cnt=%0d tc=%0b done=%0b ready=%0b, expected cnt=%0d tc=%0b done=%0b ready=0",
                   cnt, tc, done, cmd_ready, e.cnt, e.tc, e.done);
        end
      end
    end else if (tc || done) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_pulse: got tc=%0b done=%0b while idle, expected 0", tc, done);
    end
  end

  task automatic push(input logic [3:0] c, input logic t, input logic d);
    rec_t r;
    r.cnt  = c;
    r.tc   = t;
    r.done = d;
    exp_q.push_back(r);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer a command for one cycle; returns in the LOAD cycle.
  task automatic issue(input logic [3:0] s, input logic [3:0] e,
                       input logic u, input logic [1:0] r);
    tick(1);
    cmd_start  = s;
    cmd_end    = e;
    cmd_up_dnb = u;
    cmd_reps   = r;
    cmd_valid  = 1'b1;
    tick(1);
    cmd_valid  = 1'b0;
  endtask

  // Wait for the sequence to finish with a bounded cycle budget.
  task automatic drain(input string nm);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 60) begin
      tick(1);
      k++;
    end
    chk({nm, "_finished"}, (k < 60) ? 1 : 0, 1);
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_start  = '0;
    cmd_end    = '0;
    cmd_up_dnb = 1'b0;
    cmd_reps   = '0;
    pause      = 1'b0;
    abort      = 1'b0;
    tick(2);
    chk("rst_cnt",   cnt, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_tc",    tc, 0);
    chk("rst_done",  done, 0);
    reset_n = 1'b1;
    tick(1);

    // Single pass up 3..6.
    push(4'd0, 0, 0);
    for (int unsigned c = 3; c <= 5; c++) push(4'(c), 0, 0);
    push(4'd6, 1, 0);
    push(4'd6, 0, 1);
    issue(4'd3, 4'd6, 1'b1, 2'd0);
    drain("up");
    chk("up_cnt_final", cnt, 6);
    chk("up_busy_after", busy, 0);

    // Wrap with one repeat; commands offered mid-sequence must be ignored.
    push(4'd6, 0, 0);
    for (int unsigned p = 0; p < 2; p++) begin
      push(4'd14, 0, 0);
      push(4'd15, 0, 0);
      push(4'd0, 0, 0);
      push(4'd1, 1, 0);
    end
    push(4'd1, 0, 1);
    issue(4'd14, 4'd1, 1'b1, 2'd1);
    tick(2);
    cmd_start  = 4'd0;
    cmd_end    = 4'd0;
    cmd_up_dnb = 1'b0;
    cmd_reps   = 2'd3;
    cmd_valid  = 1'b1;
    tick(2);
    cmd_valid  = 1'b0;
    drain("wrap");
    chk("wrap_cnt_final", cnt, 1);

    // Down 9..5 with pause held three cycles at 7.
    push(4'd1, 0, 0);
    push(4'd9, 0, 0);
    push(4'd8, 0, 0);
    for (int unsigned k = 0; k < 5; k++) push(4'd7, 0, 0);
    push(4'd6, 0, 0);
    push(4'd5, 1, 0);
    push(4'd5, 0, 1);
    issue(4'd9, 4'd5, 1'b0, 2'd0);
    tick(3);
    pause = 1'b1;
    tick(3);
    pause = 1'b0;
    drain("pause");
    chk("pause_cnt_final", cnt, 5);

    // Abort in RUN at cnt=4; abort held into IDLE has no effect.
    push(4'd5, 0, 0);
    for (int unsigned c = 1; c <= 4; c++) push(4'(c), 0, 0);
    issue(4'd1, 4'd9, 1'b1, 2'd0);
    tick(4);
    abort = 1'b1;
    tick(1);
    chk("abort_cnt",   cnt, 4);
    chk("abort_busy",  busy, 0);
    chk("abort_ready", cmd_ready, 1);
    tick(1);
    abort = 1'b0;
    chk("abort_idle_cnt", cnt, 4);
    chk("abort_q_empty", exp_q.size(), 0);

    // Abort beats a terminal compare: start=end=2, abort in first RUN cycle.
    push(4'd4, 0, 0);
    push(4'd2, 0, 0);
    issue(4'd2, 4'd2, 1'b1, 2'd0);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_tc_busy", busy, 0);
    chk("abort_tc_cnt",  cnt, 2);

    // Equal bounds with three repeats: four tc cycles then done.
    push(4'd2, 0, 0);
    for (int unsigned p = 0; p < 4; p++) push(4'd8, 1, 0);
    push(4'd8, 0, 1);
    issue(4'd8, 4'd8, 1'b1, 2'd3);
    drain("equal");
    chk("equal_cnt_final", cnt, 8);

    // Reset mid-run discards the sequence without a done pulse.
    push(4'd8, 0, 0);
    push(4'd0, 0, 0);
    push(4'd1, 0, 0);
    issue(4'd0, 4'd15, 1'b1, 2'd0);
    tick(3);
    reset_n = 1'b0;
    #2;
    chk("midrst_cnt",   cnt, 0);
    chk("midrst_busy",  busy, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_done",  done, 0);
    tick(2);
    reset_n = 1'b1;
    tick(4);
    chk("midrst_q_empty", exp_q.size(), 0);
    chk("post_rst_cnt",   cnt, 0);
    chk("post_rst_busy",  busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cntr_seq_ctrl.md
CNTR_SEQ_CTRL -- requirements
Module: cntr_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 Parameter CNT_W, default 4, SHALL set the counter width.
REQ-003 Parameter REPS_W, default 2, SHALL set the repeat-field width.
REQ-004 Port clk, input, 1 bit, SHALL be the clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-006 Port cmd_valid, input, 1 bit, SHALL indicate a command is offered.
REQ-007 Port cmd_ready, output, 1 bit, SHALL indicate a command is accepted this cycle.
REQ-008 Port cmd_start, input, CNT_W bits, SHALL be the load value for each pass.
REQ-009 Port cmd_end, input, CNT_W bits, SHALL be the terminal value for each pass.
REQ-010 Port cmd_up_dnb, input, 1 bit, SHALL select direction: 1 counts up, 0 counts down.
REQ-011 Port cmd_reps, input, REPS_W bits, SHALL set the pass count; value N means N+1 passes.
REQ-012 Port pause, input, 1 bit, SHALL freeze counting while high.
REQ-013 Port abort, input, 1 bit, SHALL cancel the current sequence.
REQ-014 Port cnt, output, CNT_W bits, SHALL be the registered counter value.
REQ-015 Port busy, output, 1 bit, SHALL be high in every state except IDLE.
REQ-016 Port tc, output, 1 bit, SHALL pulse once per completed pass.
REQ-017 Port done, output, 1 bit, SHALL pulse once per completed sequence.

Function
REQ-018 The FSM SHALL have five states: IDLE, LOAD, RUN, HOLD, DONE.
REQ-019 cmd_ready SHALL equal (state==IDLE).
REQ-020 In IDLE, when cmd_valid and cmd_ready are both high, the block SHALL capture start/end/dir/reps into registers, clear pass_cnt, and go to LOAD.
REQ-021 In LOAD, the block SHALL load cnt with start_q and go to RUN (one cycle, no compare).
REQ-022 In RUN with pause=0 and cnt!=end_q, cnt SHALL step by ±1 modulo 2^CNT_W (15+1 wraps to 0; 0-1 wraps to 15).
REQ-023 In RUN with pause=0 and cnt==end_q, tc SHALL be high that cycle (combinational); then:
- if pass_cnt==reps_q, go to DONE with cnt held;
- otherwise load cnt with start_q and increment pass_cnt.
REQ-024 In RUN with pause=1, cnt SHALL hold, tc SHALL stay low, and the FSM SHALL go to HOLD.
REQ-025 In HOLD, cnt SHALL hold; the FSM SHALL return to RUN on the first cycle with pause=0.
REQ-026 DONE SHALL last exactly one cycle with done=1; it then goes to IDLE, and cnt keeps its final value.
REQ-027 abort SHALL take the FSM from LOAD, RUN or HOLD to IDLE on the next edge, with cnt held and tc/done not asserted in that cycle.
REQ-028 abort SHALL be ignored in IDLE and DONE.
REQ-029 Priority SHALL be abort > pause > terminal compare > step.
REQ-030 When start==end, each pass SHALL be one RUN cycle (tc in the first RUN cycle).
REQ-031 Command inputs SHALL be ignored outside IDLE; captured values SHALL be stable for the whole sequence.

Reset
REQ-032 While reset_n is low, the block SHALL hold: state=IDLE, cnt=0, pass_cnt=0, all captured registers 0.
REQ-033 While reset_n is low, outputs SHALL be busy=0, tc=0, done=0, cmd_ready=1.
REQ-034 Reset asserted mid-sequence SHALL discard the sequence immediately, with no done pulse.

Structure
REQ-035 Package cntr_seq_pkg SHALL hold the state enum type and the CNT_W/REPS_W defaults.
REQ-036 The counter SHALL be sub-module cntr_seq_core: a CNT_W up/down counter with load, enable and reset_n; cntr_seq_ctrl SHALL contain the FSM, capture registers and pass_cnt.

Verification
REQ-037 Single pass up: start=3, end=6, up, reps=0 -> cnt 3,4,5,6 on successive RUN cycles; tc high with cnt=6; done one cycle later; busy low after.
REQ-038 Wrap and repeat: start=14, end=1, up, reps=1 -> 14,15,0,1,14,15,0,1; exactly two tc pulses and one done.
REQ-039 Down count with pause: start=9, end=5, down; pause held 3 cycles at cnt=7 -> cnt stays 7 through HOLD, then resumes 6,5; no tc while paused.
REQ-040 Abort: abort at cnt=4 during RUN -> IDLE next cycle, cnt=4, no tc/done, cmd_ready=1.
REQ-041 Equal bounds plus reset: start=end=8, reps=3 -> four consecutive tc cycles, then done; reset_n pulled low mid-run -> cnt=0, IDLE, no done.
